dds_phase_gen: RTL and testbench

DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

---
 rtl/dds_phase_gen_pkg.sv | 24 ++
 rtl/dds_phase_gen_lfsr_gen.sv | 47 ++++
 rtl/dds_phase_gen.sv | 106 ++++++++++
 tb/tb_dds_phase_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dds_phase_gen_pkg.sv
// Shared DDS definitions: FSM encoding, LFSR geometry, taps and default seed.
package dds_phase_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } dds_state_e;

    // 22-bit Fibonacci LFSR, polynomial x^22 + x^21 + 1
    localparam int              LFSR_W        = 22;
    localparam int              LFSR_TAP_HI   = 21;
    localparam int              LFSR_TAP_LO   = 20;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 22'h000001;

    // One LFSR shift; an all-zero state would lock up, so it reloads the seed instead.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] seed);
        if (s == '0)
            return seed;
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/dds_phase_gen_lfsr_gen.sv
// LFSR data source with programmable bit-rate divider.
// Advances only while step_en is high; otherwise divider and LFSR are frozen.
module lfsr_gen
    import dds_phase_gen_pkg::*;
#(
    parameter int                DIV_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_en,
    input  logic [DIV_W-1:0] lfsr_div,
    output logic             lfsr0,
    output logic             lfsr_tick
);

    logic [DIV_W-1:0]  r_cnt;
    logic [LFSR_W-1:0] r_lfsr;
    logic              r_tick;
    logic              w_term;

    // ">=" rather than "==" so a divider lowered below the current count wraps at once
    assign w_term = (r_cnt >= lfsr_div);

    // Divider count, LFSR shift on terminal count, and the matching tick pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_lfsr <= LFSR_SEED;
            r_tick <= 1'b0;
        end else begin
            r_tick <= step_en && w_term;
            if (step_en) begin
                if (w_term) begin
                    r_cnt  <= '0;
                    r_lfsr <= lfsr_next(r_lfsr, LFSR_SEED);
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign lfsr0     = r_lfsr[0];
    assign lfsr_tick = r_tick;

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase generator: FSK-selectable phase accumulator with saw/square/LUT-address
// outputs and an LFSR data source for the modulation stage.
module dds_phase_gen
    import dds_phase_gen_pkg::*;
#(
    parameter int                PHASE_W   = 32,
    parameter int                OUT_W     = 12,
    parameter int                DIV_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               hold,
    input  logic [PHASE_W-1:0] tuning_word,
    input  logic [PHASE_W-1:0] fsk_word_hi,
    input  logic [PHASE_W-1:0] fsk_word_lo,
    input  logic               fsk,
    input  logic               slow_flag,
    input  logic [DIV_W-1:0]   lfsr_div,
    output logic [OUT_W-1:0]   phase_addr,
    output logic [OUT_W-1:0]   saw,
    output logic [OUT_W-1:0]   squ,
    output logic               lfsr0,
    output logic               lfsr_tick
);

    localparam int MSB = PHASE_W - 1;

    dds_phase_gen_pkg::dds_state_e r_state, w_state_nxt;

    logic [1:0]         r_sel;      // {fsk, slow_flag} sampled one cycle ahead of use
    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] w_inc;
    logic               w_step;
    logic [OUT_W-1:0]   r_addr;
    logic [OUT_W-1:0]   r_squ;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: en=0 wins over everything, hold toggles RUN/HOLD
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_RUN;
            ST_RUN:  if (hold)  w_state_nxt = ST_HOLD;
            ST_HOLD: if (!hold) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!en) w_state_nxt = ST_IDLE;
    end

    // Stepping happens in RUN unless this very cycle drops en
    assign w_step = (r_state == ST_RUN) && en;

    // Increment mux driven by the registered select
    always_comb begin
        w_inc = tuning_word;
        if (r_sel[1]) w_inc = r_sel[0] ? fsk_word_lo : fsk_word_hi;
    end

    // Tone select pipeline stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sel <= 2'b00;
        else        r_sel <= {fsk, slow_flag};
    end

    // Phase accumulator: cleared on leaving to IDLE, wraps mod 2^PHASE_W, never reset by tone changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_acc <= '0;
        else if (!en)    r_acc <= '0;
        else if (w_step) r_acc <= r_acc + w_inc;
    end

    // Registered waveform outputs, one cycle behind the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_squ  <= '1;
        end else begin
            r_addr <= r_acc[MSB -: OUT_W];
            r_squ  <= {OUT_W{~r_acc[MSB]}};
        end
    end

    assign phase_addr = r_addr;
    assign saw        = r_addr;
    assign squ        = r_squ;

    lfsr_gen #(
        .DIV_W     (DIV_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (w_step),
        .lfsr_div  (lfsr_div),
        .lfsr0     (lfsr0),
        .lfsr_tick (lfsr_tick)
    );

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen: behavioural model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_dds_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, hold, fsk, slow_flag;
    logic [31:0] tuning_word, fsk_word_hi, fsk_word_lo;
    logic [15:0] lfsr_div;
    logic [11:0] phase_addr, saw, squ;
    logic        lfsr0, lfsr_tick;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int zap_cnt = 0;

    always #5 clk = ~clk;

    dds_phase_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .hold        (hold),
        .tuning_word (tuning_word),
        .fsk_word_hi (fsk_word_hi),
        .fsk_word_lo (fsk_word_lo),
        .fsk         (fsk),
        .slow_flag   (slow_flag),
        .lfsr_div    (lfsr_div),
        .phase_addr  (phase_addr),
        .saw         (saw),
        .squ         (squ),
        .lfsr0       (lfsr0),
        .lfsr_tick   (lfsr_tick)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 run, 2 hold
    int          m_mode;
    logic [31:0] m_acc, m_inc;
    logic [1:0]  m_sel;
    int unsigned m_cnt;
    logic [21:0] m_lfsr;
    bit          m_run;
    int          zap_seen;
    logic [11:0] e_addr, e_squ;
    logic        e_lfsr0, e_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_acc = 0; m_sel = 0; m_cnt = 0; m_lfsr = 22'h000001;
            e_addr = 0; e_squ = 12'hFFF; e_lfsr0 = 1'b1; e_tick = 1'b0;
            zap_seen = zap_cnt;
        end else begin
            if (zap_seen != zap_cnt) begin
                m_lfsr = 22'h0;
                zap_seen = zap_cnt;
            end
            m_run  = (m_mode == 1) && en;
            e_addr = m_acc[31:20];
            e_squ  = m_acc[31] ? 12'h000 : 12'hFFF;
            case (m_sel)
                2'b10:   m_inc = fsk_word_hi;
                2'b11:   m_inc = fsk_word_lo;
                default: m_inc = tuning_word;
            endcase
            if (!en)        m_acc = 0;
            else if (m_run) m_acc = m_acc + m_inc;
            e_tick = 1'b0;
            if (m_run) begin
                if (m_cnt >= lfsr_div) begin
                    m_cnt  = 0;
                    m_lfsr = (m_lfsr == 0) ? 22'h000001 : {m_lfsr[20:0], m_lfsr[21] ^ m_lfsr[20]};
                    e_tick = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            e_lfsr0 = m_lfsr[0];
            m_sel   = {fsk, slow_flag};
            if (!en)              m_mode = 0;
            else if (m_mode == 0) m_mode = 1;
            else                  m_mode = hold ? 2 : 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("m_addr",  phase_addr, e_addr);
            check("m_saw",   saw,        e_addr);
            check("m_squ",   squ,        e_squ);
            check("m_lfsr0", lfsr0,      e_lfsr0);
            check("m_tick",  lfsr_tick,  e_tick);
        end
    end

    // Toggle slow_flag and check the step size: old, old, then new
    task automatic toggle_slow(input logic nv, input logic [11:0] old_s, input logic [11:0] new_s);
        logic [11:0] p0, p1, p2, p3;
        @(negedge clk);
        p0 = phase_addr;
        slow_flag = nv;
        @(negedge clk); p1 = phase_addr;
        @(negedge clk); p2 = phase_addr;
        @(negedge clk); p3 = phase_addr;
        check("fsk_d1", p1 - p0, old_s);
        check("fsk_d2", p2 - p1, old_s);
        check("fsk_d3", p3 - p2, new_s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; en = 0; hold = 0; fsk = 0; slow_flag = 0;
        tuning_word = 0; fsk_word_hi = 0; fsk_word_lo = 0; lfsr_div = 0;
        repeat (2) @(negedge clk);
        check("rst_addr",  phase_addr, 12'h000);
        check("rst_saw",   saw,        12'h000);
        check("rst_squ",   squ,        12'hFFF);
        check("rst_lfsr0", lfsr0,      1'b1);
        check("rst_tick",  lfsr_tick,  1'b0);

        // Basic sweep with LFSR divider of 3
        rst_n = 1'b1; chk_on = 1'b1;
        tuning_word = 32'h1000_0000; lfsr_div = 16'd3; en = 1'b1;
        for (int j = 0; j <= 91; j++) begin
            @(negedge clk);
            if (j >= 1) begin
                k = j / 4;
                check("sweep_addr", phase_addr, ((j - 1) * 256) & 12'hFFF);
                check("sweep_squ",  squ, (((j - 1) % 16) < 8) ? 12'hFFF : 12'h000);
                check("sweep_tick", lfsr_tick, (j % 4) == 0);
                check("sweep_lfsr0", lfsr0, (k == 0 || k == 21 || k == 22));
            end
        end

        // FSK tone switching
        fsk_word_hi = 32'h2000_0000; fsk_word_lo = 32'h0800_0000;
        fsk = 1'b1; slow_flag = 1'b0;
        repeat (4) @(negedge clk);
        toggle_slow(1'b1, 12'h200, 12'h080);
        repeat (3) @(negedge clk);
        toggle_slow(1'b0, 12'h080, 12'h200);

        // Hold for 10 cycles mid-run
        @(negedge clk);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 1) check("hold_tick", lfsr_tick, 1'b0);
        end
        hold = 1'b0;
        repeat (12) @(negedge clk);

        // en=0 beats hold=1
        hold = 1'b1; en = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_addr", phase_addr, 12'h000);
        check("idle_squ",  squ,        12'hFFF);
        hold = 1'b0; en = 1'b1; fsk = 1'b0; tuning_word = 32'h0123_4567;
        repeat (7) @(negedge clk);

        // Asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr",  phase_addr, 12'h000);
        check("arst_saw",   saw,        12'h000);
        check("arst_squ",   squ,        12'hFFF);
        check("arst_lfsr0", lfsr0,      1'b1);
        check("arst_tick",  lfsr_tick,  1'b0);
        @(negedge clk);
        rst_n = 1'b1; lfsr_div = 16'd2;
        repeat (9) @(negedge clk);
        lfsr_div = 16'd0;
        repeat (5) @(negedge clk);
        tuning_word = 32'h0;
        repeat (4) @(negedge clk);
        tuning_word = 32'hF00F_0001; lfsr_div = 16'd5;
        repeat (8) @(negedge clk);
        lfsr_div = 16'd1;
        repeat (6) @(negedge clk);

        // LFSR lockup recovery
        en = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        force dut.u_lfsr.r_lfsr = 22'h0;
        zap_cnt++;
        @(negedge clk);
        #2;
        release dut.u_lfsr.r_lfsr;
        lfsr_div = 16'd0; en = 1'b1;
        @(negedge clk);
        check("zap_pre_lfsr0", lfsr0, 1'b0);
        @(negedge clk);
        check("zap_reload", dut.u_lfsr.r_lfsr, 22'h000001);
        check("zap_tick",   lfsr_tick, 1'b1);
        repeat (30) @(negedge clk);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
